// File: rtl/csr_access_unit_pkg.sv
// Shared CSR definitions: op encoding, trap cause, and address classification.
// Used by the CSR access unit and its read-modify-write datapath.
package csr_access_unit_pkg;

    typedef enum logic [1:0] {
        CSR_OP_NONE = 2'd0,
        CSR_OP_RW   = 2'd1,
        CSR_OP_RS   = 2'd2,
        CSR_OP_RC   = 2'd3
    } csr_op_e;

    localparam logic [31:0] CSR_CAUSE_ILLEGAL_INSTR = 32'd2;

    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

    function automatic logic csr_is_implemented(input logic [11:0] addr);
        return (addr == CSR_MTVEC)    || (addr == CSR_MSCRATCH) ||
               (addr == CSR_MEPC)     || (addr == CSR_MCAUSE)   ||
               (addr == CSR_MTVAL)    || (addr == CSR_MCYCLE)   ||
               (addr == CSR_MCYCLEH)  || (addr == CSR_MINSTRET) ||
               (addr == CSR_MINSTRETH);
    endfunction

    // Counters are treated as read-only here alongside the 2'b11 address space.
    function automatic logic csr_is_readonly(input logic [11:0] addr);
        return (addr[11:10] == 2'b11)  ||
               (addr == CSR_MCYCLE)    || (addr == CSR_MCYCLEH) ||
               (addr == CSR_MINSTRET)  || (addr == CSR_MINSTRETH);
    endfunction

endpackage

// File: rtl/csr_access_unit_if.sv
// Request/response handshake between execute, the CSR access unit and writeback.
// master drives requests and accepts responses; slave is the access unit.
interface csr_access_unit_if;

    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic        req_use_imm;
    logic [31:0] req_rs1_data;
    logic [4:0]  req_uimm;
    logic        req_rs1_is_x0;
    logic        req_rd_is_x0;
    logic [11:0] req_addr;
    logic [31:0] req_pc;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_trap;
    logic [31:0] rsp_mcause;
    logic [31:0] rsp_trap_pc;

    modport master (
        output req_valid, req_op, req_use_imm, req_rs1_data, req_uimm,
               req_rs1_is_x0, req_rd_is_x0, req_addr, req_pc, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_trap, rsp_mcause,
               rsp_trap_pc
    );

    modport slave (
        input  req_valid, req_op, req_use_imm, req_rs1_data, req_uimm,
               req_rs1_is_x0, req_rd_is_x0, req_addr, req_pc, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_trap, rsp_mcause,
               rsp_trap_pc
    );

endinterface

// File: rtl/csr_access_unit_rmw_alu.sv
// Zicsr read-modify-write datapath: combines source operand with the old value.
// Field masking is left to the CSR file.
module csr_rmw_alu
    import csr_access_unit_pkg::*;
(
    input  csr_op_e     i_op,
    input  logic [31:0] i_src,
    input  logic [31:0] i_old,
    output logic [31:0] o_wdata
);

    always_comb begin
        o_wdata = i_src;
        unique case (i_op)
            CSR_OP_RW: o_wdata = i_src;
            CSR_OP_RS: o_wdata = i_old | i_src;
            CSR_OP_RC: o_wdata = i_old & ~i_src;
            default:   o_wdata = i_src;
        endcase
    end

endmodule

// File: rtl/csr_access_unit.sv
// CSR access unit: accepts one Zicsr op, reads, checks legality, writes once,
// and returns the old value or an illegal-instruction trap.
module csr_access_unit
    import csr_access_unit_pkg::*;
#(
    parameter logic [31:0] ILLEGAL_CAUSE = CSR_CAUSE_ILLEGAL_INSTR,
    parameter bit          CHECK_ADDR    = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    csr_access_unit_if.slave bus,
    output logic [11:0]      csr_raddr_o,
    input  logic [31:0]      csr_rdata_i,
    output logic             csr_we_o,
    output logic [11:0]      csr_waddr_o,
    output logic [31:0]      csr_wdata_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_RESP
    } state_e;

    state_e      r_state;
    csr_op_e     r_op;
    logic        r_use_imm;
    logic [31:0] r_rs1;
    logic [4:0]  r_uimm;
    logic        r_rs1_x0;
    logic        r_rd_x0;
    logic [11:0] r_addr;
    logic [31:0] r_pc;
    logic [31:0] r_old;
    logic        r_ready;
    logic        r_we;
    logic [31:0] r_wdata;
    logic        r_rsp_valid;
    logic        r_rsp_trap;
    logic [31:0] r_rsp_rdata;
    logic [31:0] r_rsp_mcause;
    logic [31:0] r_rsp_pc;

    logic [31:0] w_src;
    logic        w_src_nz;
    logic        w_wr_needed;
    logic        w_impl;
    logic        w_illegal;
    logic        w_do_write;
    logic [31:0] w_old;
    logic [31:0] w_wdata;

    assign w_src       = r_use_imm ? {27'b0, r_uimm} : r_rs1;
    assign w_src_nz    = r_use_imm ? (r_uimm != '0) : !r_rs1_x0;
    assign w_wr_needed = (r_op == CSR_OP_RW) || w_src_nz;
    assign w_impl      = csr_is_implemented(r_addr);
    assign w_illegal   = (r_op == CSR_OP_NONE) ||
                         (CHECK_ADDR && !w_impl) ||
                         (w_wr_needed && csr_is_readonly(r_addr));
    // Unimplemented CSRs read as zero and drop writes when not trapping.
    assign w_old       = w_impl ? csr_rdata_i : '0;
    assign w_do_write  = w_wr_needed && w_impl;

    csr_rmw_alu u_alu (
        .i_op   (r_op),
        .i_src  (w_src),
        .i_old  (w_old),
        .o_wdata(w_wdata)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= S_IDLE;
            r_op         <= CSR_OP_NONE;
            r_use_imm    <= 1'b0;
            r_rs1        <= '0;
            r_uimm       <= '0;
            r_rs1_x0     <= 1'b0;
            r_rd_x0      <= 1'b0;
            r_addr       <= '0;
            r_pc         <= '0;
            r_old        <= '0;
            r_ready      <= 1'b1;
            r_we         <= 1'b0;
            r_wdata      <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_trap   <= 1'b0;
            r_rsp_rdata  <= '0;
            r_rsp_mcause <= '0;
            r_rsp_pc     <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.req_valid && !flush_i) begin
                        r_op      <= csr_op_e'(bus.req_op);
                        r_use_imm <= bus.req_use_imm;
                        r_rs1     <= bus.req_rs1_data;
                        r_uimm    <= bus.req_uimm;
                        r_rs1_x0  <= bus.req_rs1_is_x0;
                        r_rd_x0   <= bus.req_rd_is_x0;
                        r_addr    <= bus.req_addr;
                        r_pc      <= bus.req_pc;
                        r_ready   <= 1'b0;
                        r_state   <= S_READ;
                    end
                end
                S_READ: begin
                    if (flush_i) begin
                        r_ready <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_old <= w_old;
                        if (w_illegal) begin
                            r_rsp_valid  <= 1'b1;
                            r_rsp_trap   <= 1'b1;
                            r_rsp_mcause <= ILLEGAL_CAUSE;
                            r_rsp_pc     <= r_pc;
                            r_rsp_rdata  <= '0;
                            r_state      <= S_RESP;
                        end else if (w_do_write) begin
                            r_we    <= 1'b1;
                            r_wdata <= w_wdata;
                            r_state <= S_WRITE;
                        end else begin
                            r_rsp_valid  <= 1'b1;
                            r_rsp_trap   <= 1'b0;
                            r_rsp_mcause <= '0;
                            r_rsp_pc     <= '0;
                            r_rsp_rdata  <= r_rd_x0 ? '0 : w_old;
                            r_state      <= S_RESP;
                        end
                    end
                end
                S_WRITE: begin
                    r_we         <= 1'b0;
                    r_wdata      <= '0;
                    r_rsp_valid  <= 1'b1;
                    r_rsp_trap   <= 1'b0;
                    r_rsp_mcause <= '0;
                    r_rsp_pc     <= '0;
                    r_rsp_rdata  <= r_rd_x0 ? '0 : r_old;
                    r_state      <= S_RESP;
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid  <= 1'b0;
                        r_rsp_trap   <= 1'b0;
                        r_rsp_mcause <= '0;
                        r_rsp_pc     <= '0;
                        r_rsp_rdata  <= '0;
                        r_ready      <= 1'b1;
                        r_state      <= S_IDLE;
                    end
                end
                default: begin
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready   = r_ready;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_trap    = r_rsp_trap;
    assign bus.rsp_rdata   = r_rsp_rdata;
    assign bus.rsp_mcause  = r_rsp_mcause;
    assign bus.rsp_trap_pc = r_rsp_pc;

    assign csr_raddr_o = r_addr;
    assign csr_we_o    = r_we;
    assign csr_waddr_o = r_addr;
    assign csr_wdata_o = r_wdata;

endmodule

// File: doc/csr_access_unit.md
Name: csr_access_unit

Overview:
- Initiator side of the CSR file port.
- Accepts one Zicsr operation (CSRRW/CSRRS/CSRRC and immediate forms) from the execute stage over a valid/ready handshake.
- Reads the addressed CSR, checks legality, computes the read-modify-write value, and issues a single write strobe to the CSR file.
- Returns the old value, or an illegal-instruction trap, on a response handshake toward writeback.

Parameters:
- ILLEGAL_CAUSE, 32'd2, mcause value reported on an illegal CSR access.
- CHECK_ADDR, 1, when 1 an unimplemented CSR address traps; when 0 it reads 0 and the write is dropped.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- flush_i  in  1  pipeline flush; aborts an op that has not yet committed
- req_valid_i  in  1  request valid
- req_ready_o  out  1  unit can accept a request
- req_op_i  in  2  CSR_OP_RW=1, CSR_OP_RS=2, CSR_OP_RC=3 (0 illegal)
- req_use_imm_i  in  1  source is zero-extended uimm instead of rs1
- req_rs1_data_i  in  32  rs1 value
- req_uimm_i  in  5  immediate field
- req_rs1_is_x0_i  in  1  rs1 field == 0
- req_rd_is_x0_i  in  1  rd field == 0
- req_addr_i  in  12  CSR address
- req_pc_i  in  32  PC of the CSR instruction
- csr_raddr_o  out  12  CSR file read address (combinational read)
- csr_rdata_i  in  32  CSR file read data
- csr_we_o  out  1  one-cycle CSR write strobe
- csr_waddr_o  out  12  write address
- csr_wdata_o  out  32  write data
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response accepted
- rsp_rdata_o  out  32  old CSR value (0 if rd is x0)
- rsp_trap_o  out  1  response is a trap
- rsp_mcause_o  out  32  trap cause
- rsp_trap_pc_o  out  32  faulting PC

Behaviour:
- Reset (asynchronous): state IDLE. All outputs 0 except req_ready_o=1. csr_we_o drops immediately, including in the middle of a WRITE cycle.
- Accept: req_ready_o = (state==IDLE). On req_valid_i && req_ready_o, latch all req_* fields and go to READ.
- READ (1 cycle):
  - csr_raddr_o = latched addr; capture csr_rdata_i into old_q.
  - src = req_use_imm ? {27'b0,uimm} : rs1_data.
  - wr_needed = (op==RW) || (src-field nonzero), where src-field is uimm!=0 or !rs1_is_x0.
  - illegal when any of:
    - op==0;
    - CHECK_ADDR && address not in {mtvec, mscratch, mepc, mcause, mtval, mcycle, mcycleh, minstret, minstreth};
    - wr_needed && (addr[11:10]==2'b11 || addr is mcycle/mcycleh/minstret/minstreth).
  - Next state: illegal -> RESP with trap; wr_needed -> WRITE; otherwise -> RESP.
- WRITE (1 cycle):
  - csr_we_o=1, csr_waddr_o=addr.
  - csr_wdata_o: RW = src; RS = old_q | src; RC = old_q & ~src.
  - Go to RESP. No masking here; the CSR file applies field masks.
- RESP:
  - rsp_valid_o=1; hold rsp_* stable until rsp_ready_i, then go to IDLE.
  - Trap response: rsp_trap_o=1, rsp_mcause_o=ILLEGAL_CAUSE, rsp_trap_pc_o=req_pc, rsp_rdata_o=0.
  - Normal response: rsp_rdata_o = rd_is_x0 ? 0 : old_q.
- Latency: accept at cycle 0. RESP at cycle 3 with a write, cycle 2 without.
- Throughput: at most one op in flight. Next accept is the cycle after the rsp handshake.
- flush_i:
  - In READ: abort to IDLE; no write, no response.
  - In IDLE: no effect.
  - In WRITE or RESP: ignored (committed).
  - flush_i together with req_valid_i in IDLE: request not accepted.
- csr_we_o is asserted only in WRITE; never more than one strobe per op.
- Read-only CSRs read normally when no write is implied (CSRRS/CSRRC with x0 or uimm 0).

Decomposition:
- riscv_pkg gains:
  - a csr_op_e enum (RW/RS/RC);
  - CSR_CAUSE_ILLEGAL_INSTR;
  - function csr_is_implemented(addr);
  - function csr_is_readonly(addr).
- The FSM state enum stays local.
- One natural sub-module: csr_rmw_alu (combinational op/src/old -> wdata).

Test Plan:
- CSRRW mscratch(0x340), rs1=0xDEADBEEF, old=0x12345678 -> csr_we_o pulses at cycle 2 with wdata 0xDEADBEEF; rsp_rdata_o=0x12345678 at cycle 3.
- CSRRS mtvec, rs1=0x0000_00F0, old=0x0000_0100 -> wdata 0x0000_01F0. Then CSRRC with 0x0000_0100 -> wdata 0x0000_00F0.
- CSRRS mcycle(0xB00), rs1=x0 -> no csr_we_o, rsp at cycle 2 with the read value. CSRRW mcycle -> rsp_trap_o=1, mcause=2, trap_pc=req_pc, no write.
- Unimplemented address 0x7C0 with CHECK_ADDR=1 -> trap, mcause 2. With CHECK_ADDR=0 -> rsp_rdata_o=0, no trap, no write.
- Response backpressure: hold rsp_ready_i=0 for 5 cycles -> outputs stable and req_ready_o=0; handshake then IDLE the next cycle.
- flush_i in READ -> no strobe, no response. Assert rst_i asynchronously during WRITE -> csr_we_o falls before the next edge and req_ready_o=1.
